obm_dma: RTL and testbench
==========================

# obm_dma

Object-memory DMA engine for the GPU foreground path. On a CPU trigger it copies one page of CPU work RAM (4 × NUM_OBJECTS bytes) into Object Memory at VRAM 0x800–0x8FF. It reads through a request/acknowledge memory port and writes through the same VRAM write interface the foreground renderer samples. Copies happen only during vertical blank, so the renderer never scans a half-updated object table within a visible frame.

## Interface
Parameters:
- NUM_OBJECTS, 64, objects copied; legal range 1..64; bytes moved = 4*NUM_OBJECTS
- VRAM_ADDR_WIDTH, 12, VRAM address width
- OBM_BASE, 12'h800, VRAM address of OBM byte 0

Ports:
- cpu_clk  in  1  system CPU clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_clk_enable  in  1  clock qualifier; state and counters advance only when high
- reg_write  in  1  CPU write to DMA trigger register
- reg_data  in  8  source page (high byte of source address)
- vblank  in  1  high during vertical blank (from video timing)
- mem_req  out  1  read request to CPU RAM
- mem_addr  out  16  read address = {page, 8'h00} | cnt
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  8  read data
- vram_addr  out  VRAM_ADDR_WIDTH  OBM_BASE + cnt
- vram_data  out  8  byte being written
- vram_write_enable  out  1  one enabled-cycle write strobe
- busy  out  1  high in any state except IDLE
- done  out  1  one enabled-cycle pulse at completion
- overrun  out  1  sticky: trigger arrived while busy

## Operation
- Byte counter cnt has width $clog2(4*NUM_OBJECTS) and counts 0..4*NUM_OBJECTS-1. Byte i of the source page goes to OBM byte i.
- IDLE: on reg_write, latch page=reg_data, cnt=0, clear overrun, go to WAIT_VBLANK.
- WAIT_VBLANK: if vblank, go to READ. Otherwise hold.
- READ: mem_req=1 with mem_addr stable. On mem_ack, capture mem_rdata into the data register and go to WRITE. A multi-cycle ack wait is allowed; the request stays asserted and the address stays stable until ack.
- WRITE: vram_write_enable=1, vram_addr=OBM_BASE+cnt, vram_data=captured byte.
  - If cnt is the last byte, go to DONE.
  - Else increment cnt; go to READ if vblank, else go to WAIT_VBLANK. This pauses the transfer; it resumes at the next vblank from the same cnt.
- DONE: done=1 for one cycle, then go to IDLE.
- reg_write while busy: ignored (page and cnt unchanged) and overrun set. Only the next accepted trigger clears overrun.
- mem_ack while mem_req=0: ignored.
- vblank is sampled only in WAIT_VBLANK and WRITE. A vblank drop during READ does not abort the in-flight read.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, cnt=0, page=0, data register 0
  - mem_req=0, mem_addr=0, vram_write_enable=0, vram_addr=OBM_BASE, vram_data=0
  - busy=0, done=0, overrun=0
- Reset mid-transfer: writes stop immediately and OBM keeps its partial contents. No done pulse is produced.
- All outputs are registered or decoded from registered state only. There is no combinational path from mem_ack to vram_write_enable.
- A cycle with cpu_clk_enable=0 is a full stall: no state change, outputs held. The foreground samples writes on the falling edge of enabled cycles, so each strobe produces exactly one OBM write.
- Throughput with single-cycle ack: 2 enabled cycles per byte. For NUM_OBJECTS=64, trigger-in-vblank to done is 1 (WAIT_VBLANK) + 512 + 1 = 514 enabled cycles.
- Latency:
  - reg_write to busy high: next enabled cycle.
  - vblank seen in WAIT_VBLANK to first mem_req: next enabled cycle.
- done and busy: done coincides with busy still high; busy drops the cycle after.

## Test plan
- Reset, then page 0x02 holding bytes 0x00..0xFF, vblank held high, mem_ack tied high. Required: 256 strobes at vram_addr 0x800..0x8FF with vram_data equal to the address low byte; done at enabled cycle 514; busy low after.
- mem_ack delayed 3 cycles per read. Required: mem_req and mem_addr stable until ack; 4 enabled cycles per byte; data correct.
- vblank drops after 100 bytes and returns 50 cycles later. Required: no writes and mem_req=0 while low; resumes at vram_addr 0x864; total 256 writes, no duplicates.
- reg_write 0x05 during an active transfer from page 0x02. Required: overrun=1, transfer continues from 0x02; next trigger clears overrun.
- rst_n asserted at byte 40 with cpu_clk_enable toggling 1-of-2 cycles. Required: outputs at reset values asynchronously; no strobes after; no strobe during disabled cycles before reset.

Source files
------------

// File: rtl/obm_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : obm_dma
//  Purpose  : Copies one page of CPU work RAM (4*NUM_OBJECTS bytes) into
//             Object Memory in VRAM. A transfer only moves bytes while vblank
//             is high, so the foreground never scans a half-updated table.
//  Revision : 1.0  initial release
// ============================================================================
module obm_dma #(
    parameter int                         NUM_OBJECTS     = 64,
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE        = 12'h800
) (
    input  logic                       cpu_clk,
    input  logic                       rst_n,
    input  logic                       cpu_clk_enable,
    input  logic                       reg_write,
    input  logic [7:0]                 reg_data,
    input  logic                       vblank,
    output logic                       mem_req,
    output logic [15:0]                mem_addr,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_rdata,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]                 vram_data,
    output logic                       vram_write_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    // Byte counter spans 0 .. 4*NUM_OBJECTS-1
    localparam int              CNT_W  = $clog2(4 * NUM_OBJECTS);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(4 * NUM_OBJECTS - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_VBLANK = 3'd1,
        S_READ        = 3'd2,
        S_WRITE       = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_page;
    logic [7:0]       r_data;
    logic             r_overrun;

    // Transfer sequencer: every register only moves on an enabled cycle
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_page    <= 8'h00;
            r_data    <= 8'h00;
            r_overrun <= 1'b0;
        end else if (cpu_clk_enable) begin
            // A trigger that lands while a copy is in progress is dropped and flagged
            if (reg_write && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (reg_write) begin
                        r_page    <= reg_data;
                        r_cnt     <= '0;
                        r_overrun <= 1'b0;
                        r_state   <= S_WAIT_VBLANK;
                    end
                end
                S_WAIT_VBLANK: begin
                    if (vblank) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // vblank is deliberately ignored here: an issued read always completes
                    if (mem_ack) begin
                        r_data  <= mem_rdata;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= vblank ? S_READ : S_WAIT_VBLANK;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state; no path from mem_ack
    assign mem_req           = (r_state == S_READ);
    assign mem_addr          = {r_page, 8'h00} | 16'(r_cnt);
    assign vram_write_enable = (r_state == S_WRITE);
    assign vram_addr         = OBM_BASE + VRAM_ADDR_WIDTH'(r_cnt);
    assign vram_data         = r_data;
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign overrun           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_obm_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_obm_dma
//  Purpose  : Scoreboard bench for obm_dma. Expected OBM writes are queued
//             when a transfer is triggered and popped on each write strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_obm_dma;

    localparam int NUM_OBJECTS = 64;
    localparam int NBYTES      = 4 * NUM_OBJECTS;

    logic        cpu_clk        = 1'b0;
    logic        rst_n          = 1'b0;
    logic        cpu_clk_enable = 1'b1;
    logic        reg_write      = 1'b0;
    logic [7:0]  reg_data       = 8'h00;
    logic        vblank         = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack        = 1'b0;
    logic [7:0]  mem_rdata      = 8'h00;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_write_enable;
    logic        busy;
    logic        done;
    logic        overrun;

    obm_dma #(
        .NUM_OBJECTS    (NUM_OBJECTS),
        .VRAM_ADDR_WIDTH(12),
        .OBM_BASE       (12'h800)
    ) dut (
        .cpu_clk          (cpu_clk),
        .rst_n            (rst_n),
        .cpu_clk_enable   (cpu_clk_enable),
        .reg_write        (reg_write),
        .reg_data         (reg_data),
        .vblank           (vblank),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .vram_addr        (vram_addr),
        .vram_data        (vram_data),
        .vram_write_enable(vram_write_enable),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 cpu_clk = ~cpu_clk;

    logic [7:0]  mem [0:65535];
    logic [19:0] exp_q [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   en_cyc = 0;
    int   trig_cyc = 0;
    int   last_wr_cyc = -1;
    int   exp_period = 0;
    int   exp_done_lat = 0;
    int   ack_lat = 1;
    int   ack_w = 0;
    int   rd_idx = 0;
    int   n_strobe = 0;
    int   n_done = 0;
    logic [7:0] cur_page = 8'h00;
    bit   pause_chk = 1'b0;
    bit   after_done = 1'b0;
    bit   en_toggle = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_mem_req"},  32'(mem_req), 0);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
        chk({pfx, "_vram_we"},  32'(vram_write_enable), 0);
        chk({pfx, "_vram_addr"}, 32'(vram_addr), 32'h800);
        chk({pfx, "_vram_data"}, 32'(vram_data), 0);
        chk({pfx, "_busy"},     32'(busy), 0);
        chk({pfx, "_done"},     32'(done), 0);
        chk({pfx, "_overrun"},  32'(overrun), 0);
    endtask

    // Queue the whole page and fire the trigger on an enabled cycle
    task automatic trigger(input logic [7:0] page);
        @(posedge cpu_clk); #2;
        while (!cpu_clk_enable) begin
            @(posedge cpu_clk); #2;
        end
        for (int i = 0; i < NBYTES; i++) begin
            exp_q.push_back({12'h800 + 12'(i), mem[{page, 8'h00} + 16'(i)]});
        end
        cur_page    = page;
        rd_idx      = 0;
        last_wr_cyc = -1;
        n_strobe    = 0;
        reg_data    = page;
        reg_write   = 1'b1;
        @(posedge cpu_clk); #2;
        reg_write   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < budget) begin
            @(posedge cpu_clk); #2;
            k++;
        end
        chk("done_seen", 32'(n_done - start), 1);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (n_strobe < n && k < budget) begin
            @(posedge cpu_clk); #2;
            k++;
        end
        chk("reach_strobes", 32'(n_strobe >= n), 1);
    endtask

    // Clock-enable pattern: always on, or alternating 1-of-2 cycles
    initial forever begin
        @(posedge cpu_clk);
        #1;
        cpu_clk_enable = en_toggle ? ~cpu_clk_enable : 1'b1;
    end

    // Monitor, scoreboard and CPU RAM responder, sampled on the falling edge
    initial forever begin
        logic [19:0] e;
        @(negedge cpu_clk);
        if (after_done) begin
            chk("busy_after_done", 32'(busy), 0);
            after_done = 1'b0;
        end
        if (pause_chk) begin
            chk("paused_quiet", 32'({mem_req, vram_write_enable}), 0);
        end
        if (rst_n && cpu_clk_enable) begin
            if (reg_write && !busy) trig_cyc = en_cyc;
            if (vram_write_enable) begin
                n_strobe++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("obm_write", 32'({vram_addr, vram_data}), 32'(e));
                end
                if (exp_period != 0 && last_wr_cyc >= 0) begin
                    chk("byte_period", 32'(en_cyc - last_wr_cyc), 32'(exp_period));
                end
                last_wr_cyc = en_cyc;
            end
            if (done) begin
                n_done++;
                chk("busy_with_done", 32'(busy), 1);
                if (exp_done_lat != 0) begin
                    chk("done_latency", 32'(en_cyc - trig_cyc), 32'(exp_done_lat));
                end
                after_done = 1'b1;
            end
        end
        if (!mem_req) begin
            ack_w   = 0;
            mem_ack = 1'b0;
        end else begin
            chk("mem_addr", 32'(mem_addr), 32'({cur_page, 8'h00}) + 32'(rd_idx));
            mem_ack   = (ack_w >= ack_lat - 1);
            mem_rdata = mem[mem_addr];
            if (cpu_clk_enable) begin
                ack_w++;
                if (mem_ack) rd_idx++;
            end
        end
        if (cpu_clk_enable) en_cyc++;
    end

    initial begin
        int k;
        int saved_strobe;
        int saved_done;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + 16'(i)] = 8'(i);
            mem[16'h0500 + 16'(i)] = 8'hFF - 8'(i);
        end

        // Reset state
        #12;
        chk_reset("por");
        @(posedge cpu_clk); #2;
        rst_n = 1'b1;

        // Back-to-back copy of page 0x02 with immediate ack
        exp_period   = 2;
        exp_done_lat = 514;
        ack_lat      = 1;
        trigger(8'h02);
        wait_done(2000);
        repeat (2) begin @(posedge cpu_clk); #2; end
        chk("t1_strobes", 32'(n_strobe), 256);
        chk("t1_sb_empty", 32'(exp_q.size()), 0);
        chk("t1_busy_low", 32'(busy), 0);

        // Three-cycle read latency, page 0x05
        exp_period   = 4;
        exp_done_lat = 1026;
        ack_lat      = 3;
        trigger(8'h05);
        wait_done(3000);
        repeat (2) begin @(posedge cpu_clk); #2; end
        chk("t2_strobes", 32'(n_strobe), 256);
        chk("t2_sb_empty", 32'(exp_q.size()), 0);

        // vblank drops during the write of byte 99, returns 50 cycles later
        exp_period   = 0;
        exp_done_lat = 0;
        ack_lat      = 1;
        trigger(8'h02);
        k = 0;
        while (!(vram_write_enable && vram_addr == 12'h863) && k < 1000) begin
            @(posedge cpu_clk); #2;
            k++;
        end
        chk("t3_at_byte99", 32'({vram_write_enable, vram_addr}), 32'({1'b1, 12'h863}));
        vblank = 1'b0;
        @(posedge cpu_clk); #2;
        pause_chk = 1'b1;
        repeat (49) begin @(posedge cpu_clk); #2; end
        pause_chk = 1'b0;
        vblank    = 1'b1;
        chk("t3_bytes_before_pause", 32'(n_strobe), 100);
        wait_done(2000);
        repeat (2) begin @(posedge cpu_clk); #2; end
        chk("t3_strobes", 32'(n_strobe), 256);
        chk("t3_sb_empty", 32'(exp_q.size()), 0);

        // Trigger while busy: ignored, overrun set, next trigger clears it
        trigger(8'h02);
        wait_strobes(20, 500);
        reg_data  = 8'h05;
        reg_write = 1'b1;
        @(posedge cpu_clk); #2;
        reg_write = 1'b0;
        chk("t4_overrun_set", 32'(overrun), 1);
        wait_done(2000);
        chk("t4_overrun_sticky", 32'(overrun), 1);
        chk("t4_strobes", 32'(n_strobe), 256);
        trigger(8'h02);
        chk("t4_overrun_cleared", 32'(overrun), 0);
        wait_done(2000);
        chk("t4_sb_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset at byte 40 with a 1-of-2 clock enable
        en_toggle  = 1'b1;
        exp_period = 2;
        trigger(8'h02);
        wait_strobes(40, 1000);
        @(posedge cpu_clk); #2;
        while (cpu_clk_enable) begin
            @(posedge cpu_clk); #2;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("t5_async");
        saved_strobe = n_strobe;
        saved_done   = n_done;
        exp_q.delete();
        repeat (3) begin @(posedge cpu_clk); #2; end
        rst_n = 1'b1;
        repeat (60) begin @(posedge cpu_clk); #2; end
        chk("t5_no_strobe_after_rst", 32'(n_strobe), 32'(saved_strobe));
        chk("t5_no_done", 32'(n_done), 32'(saved_done));
        chk("t5_idle", 32'(busy), 0);
        en_toggle = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
